extended_gcd: RTL

Iterative extended-Euclid engine that takes operands a and b.
Produces gcd(a,b) and the signed Bezout coefficient for a, so that a*coeff_i + b*t = gcd.
Its result pair is exactly what the combinational modular-inverse stage consumes, so gcd_result and coeff_i connect to it directly.
Used in RSA key setup with a = e and b = phi(n).

---
 rtl/extended_gcd_pkg.sv | 16 +
 rtl/extended_gcd_seq_divider.sv | 91 +++++++++
 rtl/extended_gcd.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/extended_gcd_pkg.sv
// Shared types and constants for the extended-Euclid engine and its divider.
package extgcd_pkg;

   localparam int DEF_WORD_WIDTH = 32;
   localparam int DIV_LATENCY    = DEF_WORD_WIDTH;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      DIV_START = 3'd2,
      DIV_WAIT  = 3'd3,
      UPDATE    = 3'd4,
      FINISH    = 3'd5
   } state_e;

endpackage

// File: rtl/extended_gcd_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH cycles per division.
// The first bit is produced on the div_start edge, so div_done marks the cycle the results are final.
module seq_divider
   import extgcd_pkg::*;
#(
   parameter int WIDTH = DIV_LATENCY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             div_done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] den_q;
   logic [CW-1:0]    cnt_q;
   logic             active_q;
   logic             done_q;

   logic [WIDTH-1:0] rem_in_s;
   logic [WIDTH-1:0] quo_in_s;
   logic [WIDTH-1:0] den_in_s;
   logic [WIDTH:0]   shifted_s;
   logic [WIDTH:0]   diff_s;
   logic             fits_s;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;

   // One restoring step: shift in the next dividend bit, subtract if the divisor fits.
   always_comb begin
      if (div_start) begin
         rem_in_s = {WIDTH{1'b0}};
         quo_in_s = dividend;
         den_in_s = divisor;
      end else begin
         rem_in_s = rem_q;
         quo_in_s = quo_q;
         den_in_s = den_q;
      end
      shifted_s = {rem_in_s, quo_in_s[WIDTH-1]};
      diff_s    = shifted_s - {1'b0, den_in_s};
      fits_s    = (shifted_s >= {1'b0, den_in_s});
      if (fits_s) begin
         rem_d = diff_s[WIDTH-1:0];
      end else begin
         rem_d = shifted_s[WIDTH-1:0];
      end
      quo_d = {quo_in_s[WIDTH-2:0], fits_s};
   end

   // Iteration state and completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q    <= {WIDTH{1'b0}};
         quo_q    <= {WIDTH{1'b0}};
         den_q    <= {WIDTH{1'b0}};
         cnt_q    <= {CW{1'b0}};
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (div_start) begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            den_q    <= divisor;
            cnt_q    <= CW'(1);
            active_q <= 1'b1;
         end else if (active_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               active_q <= 1'b0;
               done_q   <= 1'b1;
            end
         end
      end
   end

   assign div_done  = done_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/extended_gcd.sv
// Iterative extended-Euclid engine producing gcd(a,b) and the Bezout coefficient of a.
// Define EXTGCD_COEFF_T_EN to also produce coeff_j, the Bezout coefficient of b.
module extended_gcd
   import extgcd_pkg::*;
#(
   parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic        [WORD_WIDTH-1:0] a,
   input  logic        [WORD_WIDTH-1:0] b,
   output logic                         busy,
   output logic                         done,
   output logic signed [WORD_WIDTH-1:0] gcd_result,
   output logic signed [WORD_WIDTH-1:0] coeff_i,
`ifdef EXTGCD_COEFF_T_EN
   output logic signed [WORD_WIDTH-1:0] coeff_j,
`endif
   output logic                         range_err
);

   localparam int W = WORD_WIDTH;

   state_e         state_q;
   logic [W-1:0]   old_r_q;
   logic [W-1:0]   r_q;
   logic [W-1:0]   old_s_q;
   logic [W-1:0]   s_q;
   logic           div_start_q;
   logic           busy_q;
   logic           done_q;
   logic [W-1:0]   gcd_q;
   logic [W-1:0]   coeff_q;
   logic           range_q;

   logic           div_done_s;
   logic [W-1:0]   div_quo_s;
   logic [W-1:0]   div_rem_s;
   logic [W-1:0]   qs_s;
   logic [W-1:0]   s_d;

`ifdef EXTGCD_COEFF_T_EN
   logic [W-1:0]   old_t_q;
   logic [W-1:0]   t_q;
   logic [W-1:0]   coeff_j_q;
   logic [W-1:0]   qt_s;
   logic [W-1:0]   t_d;
`endif

   seq_divider #(
      .WIDTH (W)
   ) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .div_start (div_start_q),
      .dividend  (old_r_q),
      .divisor   (r_q),
      .div_done  (div_done_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_s)
   );

   // Truncated products are exact because every Bezout coefficient stays below 2^(W-1) in magnitude.
   assign qs_s = div_quo_s * s_q;
   assign s_d  = old_s_q - qs_s;
`ifdef EXTGCD_COEFF_T_EN
   assign qt_s = div_quo_s * t_q;
   assign t_d  = old_t_q - qt_s;
`endif

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         old_r_q     <= {W{1'b0}};
         r_q         <= {W{1'b0}};
         old_s_q     <= {W{1'b0}};
         s_q         <= {W{1'b0}};
         div_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         gcd_q       <= {W{1'b0}};
         coeff_q     <= {W{1'b0}};
         range_q     <= 1'b0;
`ifdef EXTGCD_COEFF_T_EN
         old_t_q     <= {W{1'b0}};
         t_q         <= {W{1'b0}};
         coeff_j_q   <= {W{1'b0}};
`endif
      end else begin
         div_start_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (a[W-1] || b[W-1]) begin
                     gcd_q     <= {W{1'b0}};
                     coeff_q   <= {W{1'b0}};
`ifdef EXTGCD_COEFF_T_EN
                     coeff_j_q <= {W{1'b0}};
`endif
                     range_q   <= 1'b1;
                     done_q    <= 1'b1;
                     state_q   <= FINISH;
                  end else begin
                     old_r_q <= a;
                     r_q     <= b;
                     busy_q  <= 1'b1;
                     state_q <= LOAD;
                  end
               end
            end
            LOAD: begin
               old_s_q <= W'(1);
               s_q     <= {W{1'b0}};
`ifdef EXTGCD_COEFF_T_EN
               old_t_q <= {W{1'b0}};
               t_q     <= W'(1);
`endif
               if (r_q == {W{1'b0}}) begin
                  gcd_q     <= old_r_q;
                  coeff_q   <= W'(1);
`ifdef EXTGCD_COEFF_T_EN
                  coeff_j_q <= {W{1'b0}};
`endif
                  range_q   <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= FINISH;
               end else begin
                  div_start_q <= 1'b1;
                  state_q     <= DIV_START;
               end
            end
            DIV_START: begin
               state_q <= DIV_WAIT;
            end
            DIV_WAIT: begin
               if (div_done_s) begin
                  state_q <= UPDATE;
               end
            end
            UPDATE: begin
               old_r_q <= r_q;
               r_q     <= div_rem_s;
               old_s_q <= s_q;
               s_q     <= s_d;
`ifdef EXTGCD_COEFF_T_EN
               old_t_q <= t_q;
               t_q     <= t_d;
`endif
               // The new old_r/old_s are the current r/s, so they are the result when rem is zero.
               if (div_rem_s == {W{1'b0}}) begin
                  gcd_q     <= r_q;
                  coeff_q   <= s_q;
`ifdef EXTGCD_COEFF_T_EN
                  coeff_j_q <= t_q;
`endif
                  range_q   <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= FINISH;
               end else begin
                  div_start_q <= 1'b1;
                  state_q     <= DIV_START;
               end
            end
            FINISH: begin
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign gcd_result = gcd_q;
   assign coeff_i    = coeff_q;
   assign range_err  = range_q;
`ifdef EXTGCD_COEFF_T_EN
   assign coeff_j    = coeff_j_q;
`endif

endmodule
